seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Parametrised multiplexed seven-segment display controller, the successor to the fixed 4-digit display path driven by the single-cycle CPU top. It latches a packed hex word and per-digit decimal points, then time-multiplexes them across `DIGITS` common-anode digits. It adds three features the old path lacks: a programmable scan rate, optional leading-zero blanking, and per-digit blinking. It sits between the CPU top (register/PC/switch view selection) and the board `AN`/`SEGMENT` pins.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned; legal range 1..16.
- `SCAN_DIV`, 100000: clk cycles per digit slot; legal range ≥1.
- `BLINK_W`, 5: blink phase toggles every 2^`BLINK_W` complete frames.

Ports. One clock; reset is asynchronous and active-high.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `data` input 4*`DIGITS`: hex nibbles; nibble i = `data[4i+3:4i]`; digit 0 is rightmost.
- `dp` input `DIGITS`: decimal point request per digit; 1 = lit.
- `load` input 1: on a clk edge with `load`=1, capture `data`/`dp` into the shadow registers.
- `blank_lz` input 1: level; 1 = enable leading-zero blanking.
- `blink_mask` input `DIGITS`: level; 1 = digit blinks.
- `AN` output `DIGITS`: digit enables, active-low, registered.
- `SEGMENT` output 8: {dp,g,f,e,d,c,b,a}, active-low, registered.

## Operation
- Shadow registers `sh_data`, `sh_dp` update only on `load`. Display reads shadows only, never live `data`.
- Prescaler `pcnt` counts 0..`SCAN_DIV`-1. `tick` asserts when `pcnt`=`SCAN_DIV`-1; `pcnt` then wraps to 0. With `SCAN_DIV`=1, `tick` is high every cycle.
- On `tick`, digit index `idx` advances to `idx`+1, or wraps to 0 from `DIGITS`-1. The wrap marks the end of a frame.
- Frame counter `fcnt` (`BLINK_W` bits) increments on each frame end. When it wraps from all-ones to 0, `blink_ph` toggles.
- Digit i is blanked when either condition holds:
  - Leading-zero blank: `blank_lz`=1, i≠0, and `sh_data` nibbles i..`DIGITS`-1 are all zero.
  - Blink blank: `blink_mask[i]`=1 and `blink_ph`=1.
- A blanked digit drives `SEGMENT`=8'hFF, including dp. Its `AN` bit is still asserted low so that scan timing and duty cycle are unchanged.
- Hex decode (bits 6:0, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- `SEGMENT[7]` = ~`sh_dp[idx]`.
- Exactly one `AN` bit is low at any time after the first post-reset cycle: `AN` = ~(1<<`idx`).

## Timing
- Reset values: `pcnt`=0, `idx`=0, `fcnt`=0, `blink_ph`=0, shadows=0, `AN`=all ones, `SEGMENT`=8'hFF. Reset takes effect immediately, with no clock needed, including mid-slot.
- `AN`/`SEGMENT` are registered from `idx` and the shadows every cycle, so they lag internal state by 1 clk.
  - First edge after reset release: `AN`=~1, `SEGMENT`=decode(0)=8'hC0. If `blank_lz`=1, digit 0 is never leading-zero blanked, so 8'hC0 holds in that case too.
- Digit slot length is exactly `SCAN_DIV` cycles. Frame length is `DIGITS`×`SCAN_DIV` cycles. The blink half-period is 2^`BLINK_W` frames.
- `load` and `tick` on the same edge: both take effect. The output of the following edge shows the new shadow value on the new `idx`.
- `load` held high: shadows track inputs every cycle, still with 1-cycle output latency.
- Changes to `blank_lz`/`blink_mask` are combinational into the output register and visible on the next edge.
- `fcnt`/`blink_ph` advance only on frame end, never mid-frame.

## Test plan
- Reset check (`DIGITS`=4, `SCAN_DIV`=4): assert `rst` asynchronously mid-slot with `idx`=2. Expect `AN`=4'hF and `SEGMENT`=8'hFF immediately. After release, `AN`=4'hE and `SEGMENT`=8'hC0 on the first edge.
- Scan and decode: load `data`=16'h1A2F, `dp`=4'b0100. Over one frame, expect:
  - slot 0: `AN`=E, `SEGMENT`=8E
  - slot 1: `AN`=D, `SEGMENT`=A4
  - slot 2: `AN`=B, `SEGMENT`=08 (dp lit)
  - slot 3: `AN`=7, `SEGMENT`=F9
  - Each slot lasts 4 cycles.
- Leading zeros: `data`=16'h0050, `blank_lz`=1. Expect digits 3 and 2 at FF, digit 1 at 92, digit 0 at C0. Repeat with `data`=0: digits 3..1 at FF, digit 0 at C0.
- Blink (`BLINK_W`=1): `blink_mask`=4'b0001, `data`=16'h0008. Expect digit 0 to show 80 for 2 frames, then FF for 2 frames, repeating. Other digits are unaffected.
- Load/tick collision: pulse `load` with 16'hFFFF on the same edge as `tick`. Expect the new slot's output to be 8E. Confirm that changing `data` without `load` has no effect.
- `SCAN_DIV`=1, `DIGITS`=1: `AN` stays 1'b0 and `idx` stays 0. The frame counter increments every cycle, so `blink_ph` toggles every 2^`BLINK_W` cycles.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed common-anode seven-segment scanner.
// Latches a hex word and decimal points into shadow registers, scans them
// over DIGITS digits at a programmable slot length, with optional
// leading-zero blanking and per-digit blinking. Outputs are active-low
// and registered, so they lag the scan state by one clock.
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000,
    parameter int BLINK_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            SEGMENT
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [4*DIGITS-1:0] sh_data_r;
    logic [DIGITS-1:0]   sh_dp_r;
    logic [PW-1:0]       pcnt_r;
    logic [IW-1:0]       idx_r;
    logic [BLINK_W-1:0]  fcnt_r;
    logic                blink_ph_r;
    logic [DIGITS-1:0]   an_r;
    logic [7:0]          seg_r;

    logic                tick_s;
    logic                frame_end_s;
    logic [DIGITS-1:0]   sel_s;
    logic [DIGITS-1:0]   lz_mask_s;
    logic                zero_run_s;
    logic [3:0]          nib_s;
    logic                dp_s;
    logic                blank_s;
    logic [7:0]          seg_next_s;

    assign tick_s      = (pcnt_r == PCNT_LAST);
    assign frame_end_s = tick_s && (idx_r == IDX_LAST);

    // Shadow registers: the display only ever sees data captured on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_data_r <= '0;
            sh_dp_r   <= '0;
        end else if (load) begin
            sh_data_r <= data;
            sh_dp_r   <= dp;
        end
    end

    // Prescaler: one tick every SCAN_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_r <= '0;
        end else if (tick_s) begin
            pcnt_r <= '0;
        end else begin
            pcnt_r <= pcnt_r + PW'(1);
        end
    end

    // Digit index advances on each tick and wraps at the last digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r <= '0;
        end else if (tick_s) begin
            if (idx_r == IDX_LAST) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IW'(1);
            end
        end
    end

    // Frame counter and blink phase, touched only at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_r     <= '0;
            blink_ph_r <= 1'b0;
        end else if (frame_end_s) begin
            fcnt_r <= fcnt_r + BLINK_W'(1);
            if (fcnt_r == {BLINK_W{1'b1}}) begin
                blink_ph_r <= ~blink_ph_r;
            end
        end
    end

    // One-hot digit select plus leading-zero mask scanned from the top digit.
    always_comb begin
        sel_s      = '0;
        lz_mask_s  = '0;
        zero_run_s = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_s   = zero_run_s & (sh_data_r[4*i +: 4] == 4'h0);
            lz_mask_s[i] = blank_lz && (i != 0) && zero_run_s;
            sel_s[i]     = (idx_r == IW'(i));
        end
    end

    // Pick the current nibble/dp and build the next segment pattern.
    always_comb begin
        nib_s = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            nib_s = nib_s | (sh_data_r[4*i +: 4] & {4{sel_s[i]}});
        end
        dp_s    = |(sel_s & sh_dp_r);
        blank_s = (|(sel_s & lz_mask_s)) | ((|(sel_s & blink_mask)) & blink_ph_r);
        if (blank_s) begin
            seg_next_s = 8'hFF;
        end else begin
            seg_next_s = {~dp_s, hex_decode(nib_s)};
        end
    end

    // Output register; blanked digits keep their anode enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r  <= '1;
            seg_r <= 8'hFF;
        end else begin
            an_r  <= ~sel_s;
            seg_r <= seg_next_s;
        end
    end

    assign AN      = an_r;
    assign SEGMENT = seg_r;

endmodule
